// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, word type, FSM states and GF(2^8) doubling
package aes_pkg;
  localparam int AES_NK = 4;
  localparam int AES_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;
  typedef logic [31:0] word_t;
  typedef enum logic {IDLE, EMIT} state_e;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_sched_seq_if.sv
// aes_key_sched_seq_if: key load and round-key output handshakes
interface aes_key_sched_seq_if;
  import aes_pkg::*;
  logic [32*AES_NK-1:0] key_in;
  logic key_valid;
  logic key_ready;
  logic flush;
  logic [32*AES_NK-1:0] rk_out;
  logic [3:0] rk_idx;
  logic rk_valid;
  logic rk_ready;
  logic done;
  modport slave (input key_in, key_valid, flush, rk_ready, output key_ready, rk_out, rk_idx, rk_valid, done);
  modport master (output key_in, key_valid, flush, rk_ready, input key_ready, rk_out, rk_idx, rk_valid, done);
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: combinational AES S-box applied to each byte of a word
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t w_i,
  output word_t w_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // entry b sits at the MSB end, so its LSB offset is 8*(255-b) = 8*~b
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  assign w_o = {sb(w_i[31:24]), sb(w_i[23:16]), sb(w_i[15:8]), sb(w_i[7:0])};
endmodule

// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq: iterative AES-128 key expansion emitting round keys 0..10
module aes_key_sched_seq
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input logic clk,
  input logic rst,
  aes_key_sched_seq_if.slave bus
);
  state_e state_q, state_d;
  logic [127:0] rk_q, rk_d, rk_nx;
  logic [3:0] idx_q, idx_d;
  logic valid_q, valid_d, done_q, done_d;
  logic [7:0] rcon_q, rcon_d;
  word_t sw, t, w0n, w1n, w2n, w3n;
  aes_sub_word u_sub (.w_i({rk_q[23:0], rk_q[31:24]}), .w_o(sw));
  assign t = sw ^ {rcon_q, 24'h0};
  assign w0n = rk_q[127:96] ^ t;
  assign w1n = rk_q[95:64] ^ w0n;
  assign w2n = rk_q[63:32] ^ w1n;
  assign w3n = rk_q[31:0] ^ w2n;
  assign rk_nx = {w0n, w1n, w2n, w3n};
  assign bus.key_ready = state_q == IDLE;
  assign bus.rk_out = rk_q;
  assign bus.rk_idx = idx_q;
  assign bus.rk_valid = valid_q;
  assign bus.done = done_q;
  // next state: flush beats load and transfer; last transfer returns to idle with done
  always_comb begin
    state_d = state_q;
    rk_d = rk_q;
    idx_d = idx_q;
    valid_d = valid_q;
    rcon_d = rcon_q;
    done_d = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      idx_d = 4'd0;
    end else if (state_q == IDLE && bus.key_valid) begin
      state_d = EMIT;
      rk_d = bus.key_in;
      idx_d = 4'd0;
      rcon_d = RCON_INIT;
      valid_d = 1'b1;
    end else if (state_q == EMIT && valid_q && bus.rk_ready) begin
      if (idx_q == 4'(NR)) begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d = 1'b1;
      end else begin
        rk_d = rk_nx;
        idx_d = idx_q + 4'd1;
        rcon_d = xtime(rcon_q);
      end
    end
  end
  // state and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rk_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      rcon_q <= RCON_INIT;
    end else begin
      state_q <= state_d;
      rk_q <= rk_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      done_q <= done_d;
      rcon_q <= rcon_d;
    end
  end
endmodule

// File: tb/tb_aes_key_sched_seq.sv
// tb_aes_key_sched_seq: directed FIPS-197 / zero-key checks with stall, flush and reset cases
module tb_aes_key_sched_seq;
  logic clk;
  logic rst;
  int vecs = 0;
  int errs = 0;
  logic [127:0] fexp [11];
  logic [127:0] zexp [11];
  logic [10:0] zmask;
  aes_key_sched_seq_if bus ();
  aes_key_sched_seq dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [127:0] k);
    bus.key_in = k;
    bus.key_valid = 1'b1;
    step();
    bus.key_valid = 1'b0;
  endtask
  task automatic run_seq(input bit zk, input bit rnd, input int stop);
    int e = 0;
    int cyc = 0;
    bit fin = 0;
    while (!fin && cyc < 300) begin
      bus.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("rk_valid", bus.rk_valid, 1);
      chk("rk_idx", bus.rk_idx, e);
      chk("done_low", bus.done, 0);
      chk("key_ready_low", bus.key_ready, 0);
      if (!zk) chk("rk_out_fips", bus.rk_out, fexp[e]);
      else if (zmask[e]) chk("rk_out_zero", bus.rk_out, zexp[e]);
      if (e == stop) fin = 1;
      else begin
        step();
        cyc++;
        if (bus.rk_ready) begin
          if (e == 10) begin
            fin = 1;
            chk("done_pulse", bus.done, 1);
            chk("key_ready_back", bus.key_ready, 1);
            chk("rk_valid_off", bus.rk_valid, 0);
          end else e++;
        end
      end
    end
    if (!fin) chk("seq_timeout", 0, 1);
  endtask
  initial begin
    fexp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fexp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fexp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fexp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fexp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fexp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fexp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fexp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fexp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fexp[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fexp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    foreach (zexp[i]) zexp[i] = '0;
    zexp[1]  = 128'h62636363626363636263636362636363;
    zexp[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    zmask = 11'b10000000011;
    rst = 1'b1;
    bus.key_in = '0;
    bus.key_valid = 1'b0;
    bus.flush = 1'b0;
    bus.rk_ready = 1'b0;
    repeat (2) step();
    chk("rst_rk_valid", bus.rk_valid, 0);
    chk("rst_rk_out", bus.rk_out, 0);
    chk("rst_rk_idx", bus.rk_idx, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    step();
    chk("idle_key_ready", bus.key_ready, 1);
    bus.rk_ready = 1'b1;
    load(fexp[0]);
    run_seq(0, 0, 11);
    step();
    chk("done_once", bus.done, 0);
    chk("idle_ready", bus.key_ready, 1);
    load(fexp[0]);
    run_seq(0, 1, 11);
    step();
    chk("bp_done_once", bus.done, 0);
    bus.rk_ready = 1'b1;
    load(fexp[0]);
    bus.key_valid = 1'b1;
    bus.key_in = '0;
    run_seq(0, 0, 11);
    step();
    bus.key_valid = 1'b0;
    run_seq(1, 0, 11);
    step();
    chk("zero_done_once", bus.done, 0);
    load(fexp[0]);
    run_seq(0, 0, 4);
    bus.flush = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_in = '0;
    step();
    bus.flush = 1'b0;
    bus.key_valid = 1'b0;
    chk("flush_rk_valid", bus.rk_valid, 0);
    chk("flush_rk_idx", bus.rk_idx, 0);
    chk("flush_key_ready", bus.key_ready, 1);
    chk("flush_done", bus.done, 0);
    chk("flush_rk_held", bus.rk_out, fexp[4]);
    step();
    chk("flush_no_done", bus.done, 0);
    chk("flush_no_capture", bus.rk_valid, 0);
    load(fexp[0]);
    run_seq(0, 0, 11);
    step();
    load(fexp[0]);
    run_seq(0, 0, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rk_valid", bus.rk_valid, 0);
    chk("arst_rk_out", bus.rk_out, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_rk_idx", bus.rk_idx, 0);
    #3;
    rst = 1'b0;
    step();
    chk("arst_key_ready", bus.key_ready, 1);
    chk("arst_no_done", bus.done, 0);
    load(fexp[0]);
    run_seq(0, 1, 11);
    step();
    chk("final_done_once", bus.done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/aes_key_sched_seq.md
Name: aes_key_sched_seq

Overview:
- Iterative AES-128 key-schedule stage upstream of the round datapath.
- Accepts one 128-bit cipher key over a valid/ready handshake.
- Emits round keys 0..10 in order over a second valid/ready handshake, one per accepted transfer, each tagged with its round index.
- The round keys feed the key/key_in inputs of the one-round and final-round engines. Word order is big-endian: w0 = key[127:96] ... w3 = key[31:0].

Parameters:
- NR, 10, number of expansion rounds; fixed at 10 for AES-128, other values unsupported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- key_in  in  128  cipher key; sampled on load handshake
- key_valid  in  1  key_in valid
- key_ready  out  1  block idle, can accept a key
- flush  in  1  synchronous abort of the current schedule
- rk_out  out  128  current round key (registered)
- rk_idx  out  4  round index of rk_out, 0..10
- rk_valid  out  1  rk_out/rk_idx valid
- rk_ready  in  1  consumer accepts rk_out
- done  out  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, rk_out=0, rk_idx=0, rk_valid=0, done=0, rcon=8'h01.
  - key_ready=1 once rst deasserts.
- States: IDLE, EMIT.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid&&key_ready (and !flush) at edge N: rk_out<=key_in, rk_idx<=0, rcon<=8'h01, rk_valid<=1, state<=EMIT.
  - Round key 0 is therefore visible at cycle N+1.
- EMIT:
  - key_ready=0; key_valid is ignored and no key is captured.
  - rk_out, rk_idx and rk_valid stay stable while rk_valid&&!rk_ready.
- Transfer in EMIT (rk_valid&&rk_ready):
  - If rk_idx<10:
    - rk_out <= next key computed combinationally from the current rk_out; rk_idx<=rk_idx+1.
    - rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00), giving 01,02,04,08,10,20,40,80,1b,36.
  - If rk_idx==10: rk_valid<=0, state<=IDLE, done<=1 for exactly one cycle.
- Throughput: with rk_ready held high, keys 0..10 appear on 11 consecutive cycles. done is high on the cycle after the key-10 transfer. key_ready rises on that same cycle.
- Next-key arithmetic, all 32-bit XOR:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord(w) = {w[23:0],w[31:24]} and SubWord applies the AES S-box per byte.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- flush:
  - At the next edge: state<=IDLE, rk_valid<=0, rk_idx<=0, done stays 0. rk_out is held.
  - flush has priority over a simultaneous key load or rk transfer. A key offered in the same cycle is not accepted.
- Reset mid-operation aborts at once; no done pulse.
- rk_idx never exceeds 10 and never wraps.

Decomposition:
- Shared package aes_pkg:
  - AES_NK=4, AES_NR=10.
  - Rcon initial value 8'h01 and reduction constant 8'h1b.
  - Function xtime.
  - 32-bit word typedef.
- Sub-module aes_sub_word: purely combinational 4-byte S-box, 32 in to 32 out, no clock, so next-key generation fits in one cycle.
- FSM, rcon register and XOR chain live in aes_key_sched_seq.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - idx0 = key.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles; done pulses once; key_ready returns high.
- All-zero key:
  - idx1 = 62636363626363636263636362636363.
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: toggle rk_ready pseudo-randomly.
  - Output is held stable while stalled.
  - Sequence matches the first test exactly; no key is skipped or duplicated.
- key_valid held high during EMIT with a different key_in -> ignored; emitted keys unchanged; new key accepted only after done.
- flush asserted at idx4, with key_valid also high that cycle:
  - Next cycle rk_valid=0, state IDLE, no done, new key not captured.
  - A subsequent load restarts at idx0 with rcon 01.
- rst asserted asynchronously mid-cycle at idx7 -> rk_valid, rk_out and done go to 0 immediately; after release, key_ready=1 and a full schedule runs correctly.
